// File: rtl/sad_pkg.sv
// Shared definitions for the SAD buffer fill engine: FSM encoding, buffer selects, word stride.
package sad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } fill_state_e;

    localparam logic BUF_A = 1'b0;
    localparam logic BUF_B = 1'b1;

    localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/sad_buffer_fill_unit_if.sv
// Load-request, data-memory read and SAD buffer write/status signals of the buffer fill engine.
interface sad_buffer_fill_unit_if #(
    parameter int unsigned WORDS  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned IDX_W = $clog2(WORDS);

    logic              load_a;
    logic              load_b;
    logic [ADDR_W-1:0] load_addr;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic [DATA_W-1:0] mem_rd_data;
    logic              buf_wr_en;
    logic              buf_wr_sel;
    logic [IDX_W-1:0]  buf_wr_idx;
    logic [DATA_W-1:0] buf_wr_data;
    logic              buf_a_consume;
    logic              buf_b_consume;
    logic              buf_a_valid;
    logic              buf_b_valid;
    logic              all_buf_flags;

    // Fill engine side
    modport master (
        input  load_a, load_b, load_addr, mem_rd_ack, mem_rd_data,
               buf_a_consume, buf_b_consume,
        output mem_rd_req, mem_rd_addr, buf_wr_en, buf_wr_sel, buf_wr_idx,
               buf_wr_data, buf_a_valid, buf_b_valid, all_buf_flags
    );

    // Decode / memory / SAD-path side
    modport slave (
        output load_a, load_b, load_addr, mem_rd_ack, mem_rd_data,
               buf_a_consume, buf_b_consume,
        input  mem_rd_req, mem_rd_addr, buf_wr_en, buf_wr_sel, buf_wr_idx,
               buf_wr_data, buf_a_valid, buf_b_valid, all_buf_flags
    );

endinterface

// File: rtl/sad_fill_addr_gen.sv
// Fill address generator: latches the base address, walks the word index and flags the last word.
module sad_fill_addr_gen
    import sad_pkg::*;
#(
    parameter int unsigned WORDS  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [ADDR_W-1:0]          load_base,
    input  logic                       advance,
    output logic [ADDR_W-1:0]          addr,
    output logic [$clog2(WORDS)-1:0]   idx,
    output logic                       last
);
    localparam int unsigned IDX_W = $clog2(WORDS);

    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  idx_q;

    // Index wraps naturally because WORDS is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            base_q <= load_base;
            idx_q  <= '0;
        end else if (advance) begin
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign addr = base_q + ADDR_W'(idx_q) * ADDR_W'(WORD_STRIDE);
    assign idx  = idx_q;
    assign last = (idx_q == IDX_W'(WORDS - 1));

endmodule

// File: rtl/sad_buffer_fill_unit.sv
// SAD buffer fill engine: serves LBUFA/LBUFB loads from decode by streaming WORDS memory words
// into buffer A or B, and reports idle via all_buf_flags so further loads stall in ID.
module sad_buffer_fill_unit
    import sad_pkg::*;
#(
    parameter int unsigned WORDS  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    sad_buffer_fill_unit_if.master bus
);
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] FILL_SPAN = ADDR_W'(WORD_STRIDE * WORDS);

    fill_state_e       state_q, state_d;
    logic              pending_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              sel_q;
    logic              buf_a_valid_q, buf_b_valid_q;

    logic              idle_c;
    logic              start_c;
    logic              start_sel_c;
    logic [ADDR_W-1:0] start_addr_c;
    logic              set_pend_c;
    logic              clr_pend_c;
    logic              commit_c;
    logic              advance_c;
    logic              last_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] wr_data_c;

    assign idle_c    = (state_q == ST_IDLE) && !pending_q;
    assign advance_c = (state_q == ST_FILL) && bus.mem_rd_ack;

    // Next-state and fill-start decode
    always_comb begin
        state_d      = state_q;
        start_c      = 1'b0;
        start_sel_c  = BUF_A;
        start_addr_c = bus.load_addr;
        set_pend_c   = 1'b0;
        clr_pend_c   = 1'b0;
        commit_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (idle_c && (bus.load_a || bus.load_b)) begin
                    state_d     = ST_FILL;
                    start_c     = 1'b1;
                    start_sel_c = bus.load_a ? BUF_A : BUF_B;
                    set_pend_c  = bus.load_a && bus.load_b;
                end
            end
            ST_FILL: begin
                if (bus.mem_rd_ack && last_c) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit_c = 1'b1;
                if (pending_q) begin
                    state_d      = ST_FILL;
                    start_c      = 1'b1;
                    start_sel_c  = BUF_B;
                    start_addr_c = pend_addr_q;
                    clr_pend_c   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            sel_q       <= BUF_A;
        end else begin
            state_q <= state_d;
            if (set_pend_c) begin
                pending_q   <= 1'b1;
                pend_addr_q <= bus.load_addr + FILL_SPAN;
            end else if (clr_pend_c) begin
                pending_q   <= 1'b0;
            end
            if (start_c) begin
                sel_q <= start_sel_c;
            end
        end
    end

    // Commit sets the valid of the buffer just filled; it beats a same-cycle consume
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            buf_a_valid_q <= 1'b0;
            buf_b_valid_q <= 1'b0;
        end else begin
            if (commit_c && sel_q == BUF_A) begin
                buf_a_valid_q <= 1'b1;
            end else if ((start_c && start_sel_c == BUF_A) || bus.buf_a_consume) begin
                buf_a_valid_q <= 1'b0;
            end
            if (commit_c && sel_q == BUF_B) begin
                buf_b_valid_q <= 1'b1;
            end else if ((start_c && start_sel_c == BUF_B) || bus.buf_b_consume) begin
                buf_b_valid_q <= 1'b0;
            end
        end
    end

    sad_fill_addr_gen #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .load      (start_c),
        .load_base (start_addr_c),
        .advance   (advance_c),
        .addr      (rd_addr_c),
        .idx       (idx_c),
        .last      (last_c)
    );

    assign wr_data_c = advance_c ? bus.mem_rd_data : '0;

    assign bus.mem_rd_req    = (state_q == ST_FILL);
    assign bus.mem_rd_addr   = (state_q == ST_FILL) ? rd_addr_c : '0;
    assign bus.buf_wr_en     = advance_c;
    assign bus.buf_wr_sel    = sel_q;
    assign bus.buf_wr_idx    = advance_c ? idx_c : '0;
    assign bus.buf_wr_data   = wr_data_c;
    assign bus.buf_a_valid   = buf_a_valid_q;
    assign bus.buf_b_valid   = buf_b_valid_q;
    assign bus.all_buf_flags = idle_c;

endmodule
